// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared Galois LFSR helpers for lfsr_bank
// Contents: lfsr_step (one Galois shift), reset_seed (per-channel reset seed),
//           default maximal tap masks for 8/16/24/32-bit registers.
// Helpers compute at LFSR_MAXW bits; callers truncate to their own width.
package lfsr_pkg;

  localparam int LFSR_MAXW = 64;

  // Maximal-length Galois tap masks (x^n term implied by the shift out of the MSB)
  localparam logic [7:0]  LFSR_TAPS_8  = 8'h1D;
  localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;
  localparam logic [23:0] LFSR_TAPS_24 = 24'h000087;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h0040_0007;

  function automatic logic [LFSR_MAXW-1:0] width_mask(input int nbits);
    if (nbits >= LFSR_MAXW) return '1;
    return (64'd1 << nbits) - 64'd1;
  endfunction

  // One Galois shift of an nbits-wide register; bits above nbits come out zero.
  function automatic logic [LFSR_MAXW-1:0] lfsr_step(input logic [LFSR_MAXW-1:0] state,
                                                    input logic [LFSR_MAXW-1:0] taps,
                                                    input logic                 invert,
                                                    input int                   nbits);
    logic [LFSR_MAXW-1:0] mask;
    logic [LFSR_MAXW-1:0] shifted;
    logic                 fb;
    mask    = width_mask(nbits);
    fb      = (|(state & (64'd1 << (nbits - 1)))) ^ invert;
    shifted = (state << 1) & mask;
    return shifted ^ (fb ? (taps & mask) : '0);
  endfunction

  // All ones with the channel index XORed into the low bits; never zero while ch < 2^nbits - 1.
  function automatic logic [LFSR_MAXW-1:0] reset_seed(input int ch, input int nbits);
    return width_mask(nbits) ^ 64'(unsigned'(ch));
  endfunction

endpackage

// File: rtl/lfsr_chan.sv
// rtl/lfsr_chan.sv - one LFSR channel: state register, unrolled stepping, optional wrap detect
// Ports: clk, reset (sync, active-high), enable (step STEPS shifts), load (take seed),
//        seed (already zero-guarded by the bank), state (registered), wrap (registered pulse).
// Macro LFSR_BANK_WRAP_DETECT_EN builds the seed register and wrap comparator; otherwise wrap = 0.
module lfsr_chan
  import lfsr_pkg::*;
#(
  parameter int               NBITS  = 8,
  parameter logic [NBITS-1:0] TAPS   = 8'h1D,
  parameter int               STEPS  = 1,
  parameter int               INVERT = 0,
  parameter int               CH     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [NBITS-1:0] seed,
  output logic [NBITS-1:0] state,
  output logic             wrap
);

  localparam logic [NBITS-1:0] RST_SEED = NBITS'(reset_seed(CH, NBITS));

  logic [LFSR_MAXW-1:0] acc;
  logic [NBITS-1:0]     next_state;

  // STEPS shifts chained combinationally so a whole enabled cycle lands in one edge
  always_comb begin
    acc = LFSR_MAXW'(state);
    for (int i = 0; i < STEPS; i++) begin
      acc = lfsr_step(acc, LFSR_MAXW'(TAPS), INVERT != 0, NBITS);
    end
  end

  assign next_state = acc[NBITS-1:0];

  generate
    if (NBITS < LFSR_MAXW) begin : g_acc_hi
      logic unused_acc_hi;
      assign unused_acc_hi = ^acc[LFSR_MAXW-1:NBITS];
    end
  endgenerate

`ifdef LFSR_BANK_WRAP_DETECT_EN
  logic [NBITS-1:0] seed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RST_SEED;
      seed_q <= RST_SEED;
      wrap   <= 1'b0;
    end else if (load) begin
      state  <= seed;
      seed_q <= seed;
      wrap   <= 1'b0;
    end else if (enable) begin
      state  <= next_state;
      // Only the post-step state is compared; intermediate shifts never count
      wrap   <= (next_state == seed_q);
    end else begin
      wrap   <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RST_SEED;
    end else if (load) begin
      state <= seed;
    end else if (enable) begin
      state <= next_state;
    end
  end

  assign wrap = 1'b0;
`endif

endmodule

// File: rtl/lfsr_bank.sv
// rtl/lfsr_bank.sv - NCH-channel Galois LFSR bank sharing one tap polynomial
// Ports: clk, reset (sync, active-high), enable (advance all channels), load/load_ch/seed
//        (reseed one channel), lfsr (channel i at [i*NBITS +: NBITS]), seed_err (zero seed
//        replaced), wrap (per-channel return-to-seed pulse).
// Macro LFSR_BANK_WRAP_DETECT_EN enables wrap detection; undefined ties wrap to 0.
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter int               NBITS  = 8,
  parameter logic [NBITS-1:0] TAPS   = 8'h1D,
  parameter int               NCH    = 2,
  parameter int               STEPS  = 1,
  parameter int               INVERT = 0,
  localparam int              LCW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [LCW-1:0]       load_ch,
  input  logic [NBITS-1:0]     seed,
  output logic [NCH*NBITS-1:0] lfsr,
  output logic                 seed_err,
  output logic [NCH-1:0]       wrap
);

  logic [NCH-1:0] load_hit;
  logic           zero_guard;

  // A zero seed would lock a non-inverting LFSR at zero forever
  assign zero_guard = (INVERT == 0) && (seed == '0);

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chan
      localparam logic [NBITS-1:0] RS = NBITS'(reset_seed(g, NBITS));

      logic [NBITS-1:0] chan_seed;

      // load_ch values at or beyond NCH match no channel and are dropped silently
      assign load_hit[g] = load && (load_ch == LCW'(g));
      assign chan_seed   = zero_guard ? RS : seed;

      lfsr_chan #(
        .NBITS  (NBITS),
        .TAPS   (TAPS),
        .STEPS  (STEPS),
        .INVERT (INVERT),
        .CH     (g)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (load_hit[g]),
        .seed   (chan_seed),
        .state  (lfsr[g*NBITS +: NBITS]),
        .wrap   (wrap[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      seed_err <= 1'b0;
    end else begin
      seed_err <= zero_guard && (|load_hit);
    end
  end

endmodule

// File: doc/lfsr_bank.md
# lfsr_bank

Multi-channel, parametrised Galois LFSR generator for the VGA demo pipelines (starfield, noise and sprite jitter). It holds NCH independent shift registers that share one tap polynomial. Each enabled cycle advances every channel by STEPS shifts. Any single channel can be reseeded at run time, zero-state lock-up is guarded against, and an optional per-channel wrap pulse reports that a channel has returned to its seed. It replaces single-channel instances where a design needs several decorrelated random streams from one block.

## Interface
Parameters:
- NBITS, 8, register width per channel; must be ≥ 2.
- TAPS, 8'h1D, Galois tap mask, NBITS wide; 8'h1D is maximal, period 255.
- NCH, 2, channel count; must satisfy 1 ≤ NCH < 2^NBITS.
- STEPS, 1, shifts applied per enabled cycle; must be ≥ 1.
- INVERT, 0, inverts the feedback bit when 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  advance all channels this cycle.
- load  in  1  reseed channel load_ch this cycle.
- load_ch  in  $clog2(NCH) (min 1)  target channel for load.
- seed  in  NBITS  seed value for load.
- lfsr  out  NCH*NBITS  channel states; channel i occupies bits [i*NBITS +: NBITS].
- seed_err  out  1  one-cycle pulse: a rejected zero seed was replaced.
- wrap  out  NCH  one-cycle pulse per channel: the state has returned to its seed.

## Operation
- Single shift f(s): fb = s[NBITS-1] ^ INVERT; next = {s[NBITS-2:0],1'b0} ^ (fb ? TAPS : 0).
- Enabled step: next state = f applied STEPS times, built as combinational unrolled logic in one cycle.
- Reset seed of channel i: {NBITS{1'b1}} ^ i. Channel 0 resets to all ones, channel 1 to all ones with bit 0 cleared, and so on. The reset seed is never zero.
- Priority per channel, highest first: reset, then load (when load_ch == i), then enable, then hold.
- load overrides enable only for the addressed channel. The other channels still step if enable = 1.
- load_ch ≥ NCH: the load is ignored and there is no error pulse.
- Zero guard: applies only when INVERT = 0. Loading seed = 0 stores the channel's reset seed instead and pulses seed_err.
- With INVERT = 1, a zero seed is legal and seed_err never asserts.
- Arithmetic is pure XOR/shift at NBITS width. Bits shifted out of the MSB are dropped.

## Timing
- All outputs are registered. lfsr updates on the clk edge after enable or load is sampled: 1-cycle latency.
- Reset values:
  - lfsr: reset seeds.
  - seed_err = 0.
  - wrap = 0.
  - Stored seeds: the reset seeds.
- seed_err is high for exactly the cycle after the offending load.
- wrap[i] is high in the cycle where the lfsr channel i, having just stepped, equals stored seed i. A load never raises wrap.
- With STEPS > 1, wrap is checked only on the post-step state. Intermediate states do not count.
- Reset asserted mid-run restores every channel on the next edge and clears pending pulses. A simultaneous load or enable is ignored.

## Configuration
- Macro LFSR_BANK_WRAP_DETECT_EN.
- Defined: per-channel seed registers plus NBITS-wide comparators are built, and wrap behaves as specified above.
- Undefined: no seed storage or comparators are built. wrap is tied to 0. All other behaviour is identical.

## Structure
- Shared package lfsr_pkg holds:
  - function lfsr_step(state, taps, invert) for a single shift;
  - a localparam for the default maximal tap masks (8/16/24/32 bit);
  - function reset_seed(ch, nbits).
- One sub-module, lfsr_chan, covers one channel: state register, STEPS-unrolled next-state logic, optional seed register and wrap comparator.
- The bank generates NCH instances and handles load_ch decode and the zero-guard/seed_err logic.

## Test plan
All scenarios use NBITS=8, TAPS=8'h1D, NCH=2, INVERT=0 unless noted.
- Reset, then one enable cycle: lfsr ch0 0xFF→0xE3 and ch1 0xFE→0xE1. seed_err=0, wrap=0.
- STEPS=2: reset, then one enable: ch0 0xFF→0xDB in a single cycle.
- Reset, then 255 consecutive enables: ch0 returns to 0xFF and wrap[0] pulses on exactly that cycle, never earlier. With the macro undefined, wrap stays 0.
- load=1, load_ch=1, seed=0x5A with enable=1: ch1 = 0x5A and ch0 steps to 0xE3. After 255 further enables, wrap[1] pulses as ch1 reads 0x5A.
- load, load_ch=0, seed=0x00: ch0 = 0xFF and seed_err pulses one cycle. Repeat with INVERT=1: ch0 = 0x00 and there is no seed_err.
- Mid-run reset held together with load and enable: next edge gives ch0 = 0xFF, ch1 = 0xFE, and all pulses are 0.
